// File: rtl/fwft_rr_arbiter.sv
// fwft_rr_arbiter: round-robin scheduler that pops one first-word-fall-through
// FIFO per cycle and forwards the head word, tagged with its port index, to a
// single shared consumer. It can keep granting a busy port for up to BURST
// words before rotating.
//
// Build option FWFT_RR_ARBITER_SKID_EN: adds a 2-entry output buffer so that
// pops depend only on registered occupancy and not on out_stall.
// Without it, a single output register is used and a pop may happen in the
// same cycle that the consumer accepts the held word.
module fwft_rr_arbiter #(
  parameter  int NUM_PORTS = 4,
  parameter  int WIDTH     = 32,
  parameter  int BURST     = 1,
  localparam int SRC_W     = $clog2(NUM_PORTS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_PORTS-1:0]       fifo_empty,
  input  logic [NUM_PORTS*WIDTH-1:0] fifo_dout,
  output logic [NUM_PORTS-1:0]       fifo_rd_en,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [SRC_W-1:0]           out_src,
  input  logic                       out_stall
);

  // Arbiter state: the last granted port and the burst words it has left.
  logic [SRC_W-1:0] last_q, last_d;
  logic [3:0]       bcnt_q, bcnt_d;

  logic             can_load;
  logic             any_req;
  logic             keep;
  logic             pop;
  logic [SRC_W-1:0] sel;
  logic [WIDTH-1:0] head_data;

  assign any_req = (~fifo_empty != '0);
  assign keep    = (bcnt_q != 4'd0) && !fifo_empty[last_q];
  // Reset gates the pop strobe, so no FIFO loses a word in the reset cycle.
  assign pop     = can_load && any_req && !rst;

  // Choose the port. Keep the current port while its burst lasts. Otherwise
  // take the first non-empty port after last_q, wrapping around.
  always_comb begin
    logic             found;
    logic [SRC_W:0]   sum;
    logic [SRC_W-1:0] cand;
    found = 1'b0;
    sel   = last_q;
    sum   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      sum = {1'b0, last_q} + (SRC_W+1)'(k);
      if (sum >= (SRC_W+1)'(NUM_PORTS)) sum = sum - (SRC_W+1)'(NUM_PORTS);
      cand = sum[SRC_W-1:0];
      if (!found && !fifo_empty[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
    if (keep) sel = last_q;
  end

  // Head-word mux and one-hot pop strobe for the selected port.
  always_comb begin
    head_data  = '0;
    fifo_rd_en = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (sel == SRC_W'(i)) begin
        head_data     = fifo_dout[i*WIDTH +: WIDTH];
        fifo_rd_en[i] = pop;
      end
    end
  end

  // Next arbiter state. A new grant reloads the burst counter and a continued
  // grant counts it down. A load slot with nothing to pop ends the burst.
  always_comb begin
    last_d = last_q;
    bcnt_d = bcnt_q;
    if (pop) begin
      last_d = sel;
      if ((sel != last_q) || (bcnt_q == 4'd0)) bcnt_d = 4'(BURST - 1);
      else                                     bcnt_d = bcnt_q - 4'd1;
    end else if (can_load && !rst) begin
      bcnt_d = 4'd0;
    end
  end

  // Arbiter state register. Reset points last_q at the top port so port 0
  // wins the first scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= SRC_W'(NUM_PORTS - 1);
      bcnt_q <= 4'd0;
    end else begin
      last_q <= last_d;
      bcnt_q <= bcnt_d;
    end
  end

`ifdef FWFT_RR_ARBITER_SKID_EN
  // Two-entry buffer: h_* is the head presented to the consumer, t_* is the
  // second word waiting behind it.
  logic [1:0]       occ_q;
  logic [WIDTH-1:0] h_data_q, t_data_q;
  logic [SRC_W-1:0] h_src_q, t_src_q;
  logic             drain;

  assign can_load  = (occ_q < 2'd2);
  assign drain     = (occ_q != 2'd0) && !out_stall;
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = h_data_q;
  assign out_src   = h_src_q;

  // In-order fill and drain. When the buffer empties, the head fields keep
  // their last values.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q    <= 2'd0;
      h_data_q <= '0;
      h_src_q  <= '0;
      t_data_q <= '0;
      t_src_q  <= '0;
    end else begin
      case ({pop, drain})
        2'b10: begin
          if (occ_q == 2'd0) begin
            h_data_q <= head_data;
            h_src_q  <= sel;
          end else begin
            t_data_q <= head_data;
            t_src_q  <= sel;
          end
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          if (occ_q == 2'd2) begin
            h_data_q <= t_data_q;
            h_src_q  <= t_src_q;
          end
          occ_q <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            h_data_q <= head_data;
            h_src_q  <= sel;
          end else begin
            h_data_q <= t_data_q;
            h_src_q  <= t_src_q;
            t_data_q <= head_data;
            t_src_q  <= sel;
          end
        end
        default: ;
      endcase
    end
  end
`else
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [SRC_W-1:0] out_src_q;

  assign can_load  = !out_valid_q || !out_stall;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

  // Single output register. It loads when the consumer can take a word and
  // holds the word while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else if (can_load) begin
      out_valid_q <= pop;
      if (pop) begin
        out_data_q <= head_data;
        out_src_q  <= sel;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fwft_rr_arbiter.sv
// Directed bench for fwft_rr_arbiter. It has two instances, BURST=1 and
// BURST=4. Each instance is fed by behavioural FWFT FIFO models, and the
// expected sequences are hand-derived.
module tb_fwft_rr_arbiter;
  localparam int NP = 4;
  localparam int W  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mclr;
  always #5 clk = ~clk;

  // FIFO models, indexed [dut][port].
  logic [W-1:0]    mem [2][NP][16];
  logic [4:0]      cnt [2][NP];
  logic [4:0]      rp  [2][NP];
  logic [NP-1:0]   empty [2];
  logic [NP*W-1:0] dout  [2];
  logic [NP-1:0]   rd_en [2];
  logic [1:0]      stall;
  logic [1:0]      vld;
  logic [W-1:0]    data [2];
  logic [1:0]      src  [2];

  int nchk = 0;
  int nerr = 0;

  fwft_rr_arbiter #(.NUM_PORTS(NP), .WIDTH(W), .BURST(1)) u_dut (
    .clk(clk), .rst(rst), .fifo_empty(empty[0]), .fifo_dout(dout[0]),
    .fifo_rd_en(rd_en[0]), .out_valid(vld[0]), .out_data(data[0]),
    .out_src(src[0]), .out_stall(stall[0]));

  fwft_rr_arbiter #(.NUM_PORTS(NP), .WIDTH(W), .BURST(4)) u_dut4 (
    .clk(clk), .rst(rst), .fifo_empty(empty[1]), .fifo_dout(dout[1]),
    .fifo_rd_en(rd_en[1]), .out_valid(vld[1]), .out_data(data[1]),
    .out_src(src[1]), .out_stall(stall[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input int d, input int p, input logic [W-1:0] v);
    mem[d][p][cnt[d][p][3:0]] = v;
    cnt[d][p] = cnt[d][p] + 5'd1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FWFT view: the head word is visible whenever the FIFO is non-empty.
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      empty[d] = '1;
      dout[d]  = '0;
      for (int i = 0; i < NP; i++) begin
        empty[d][i]         = (rp[d][i] == cnt[d][i]);
        dout[d][i*W +: W]   = mem[d][i][rp[d][i][3:0]];
      end
    end
  end

  // Advance the read pointers on pops, and flag any pop of an empty FIFO.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NP; i++) begin
        if (mclr)             rp[d][i] <= 5'd0;
        else if (rd_en[d][i]) rp[d][i] <= rp[d][i] + 5'd1;
      end
      if (!mclr) chk("pop_nonempty", 32'(rd_en[d] & empty[d]), 32'd0);
    end
  end

  logic [1:0] t2_s [8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
  logic [7:0] t2_d [8]  = '{8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hA1, 8'hB1, 8'hC1, 8'hD1};
  logic [1:0] t6_s [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};
  logic [7:0] t6_d [12] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h12, 8'h13,
                            8'h04, 8'h05, 8'h14, 8'h15};

  initial begin
    mclr  = 1'b1;
    stall = 2'b00;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NP; i++) begin
        cnt[d][i] = 5'd0;
        for (int k = 0; k < 16; k++) mem[d][i][k] = '0;
      end
    repeat (2) tick();
    mclr = 1'b0;

    // Reset values, then 10 idle cycles with every FIFO empty.
    chk("rst_valid", 32'(vld[0]), 32'd0);
    chk("rst_data",  data[0], 32'd0);
    chk("rst_src",   32'(src[0]), 32'd0);
    chk("rst_rden",  32'(rd_en[0]), 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_valid", 32'(vld[0]), 32'd0);
      chk("idle_rden",  32'(rd_en[0]), 32'd0);
    end

    // Plain round robin across four ports, two words each.
    for (int p = 0; p < NP; p++) begin
      push(0, p, 32'(8'hA0 + 8'(p*16)));
      push(0, p, 32'(8'hA1 + 8'(p*16)));
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rr_valid", 32'(vld[0]), 32'd1);
      chk("rr_src",   32'(src[0]), 32'(t2_s[k]));
      chk("rr_data",  data[0], 32'(t2_d[k]));
    end
    tick();
    chk("rr_drained", 32'(vld[0]), 32'd0);

    // A single busy port streams back to back.
    push(0, 2, 32'h21); push(0, 2, 32'h22); push(0, 2, 32'h23);
    #1 chk("solo_rden0", 32'(rd_en[0]), 32'b0100);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("solo_src",  32'(src[0]), 32'd2);
      chk("solo_data", data[0], 32'(32'h21 + k));
      chk("solo_rden", 32'(rd_en[0]), (k < 2) ? 32'b0100 : 32'd0);
    end
    tick();
    chk("solo_drained", 32'(vld[0]), 32'd0);

    // Back-pressure holds the word. The next word follows on release.
    push(0, 1, 32'h55); push(0, 1, 32'h66);
    tick();
    chk("stall_first", data[0], 32'h55);
    stall[0] = 1'b1;
`ifndef FWFT_RR_ARBITER_SKID_EN
    #1 chk("stall_rden0", 32'(rd_en[0]), 32'd0);
`endif
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("stall_valid", 32'(vld[0]), 32'd1);
      chk("stall_data",  data[0], 32'h55);
      chk("stall_src",   32'(src[0]), 32'd1);
`ifndef FWFT_RR_ARBITER_SKID_EN
      chk("stall_rden",  32'(rd_en[0]), 32'd0);
`endif
    end
    stall[0] = 1'b0;
    tick();
    chk("release_valid", 32'(vld[0]), 32'd1);
    chk("release_data",  data[0], 32'h66);
    tick();
    chk("release_drained", 32'(vld[0]), 32'd0);

    // Reset in mid-transfer: the held word is discarded and port 0 wins first.
    push(0, 2, 32'h91); push(0, 2, 32'h92); push(0, 0, 32'h81);
    tick();
    chk("pre_rst_src",  32'(src[0]), 32'd2);
    chk("pre_rst_data", data[0], 32'h91);
    rst = 1'b1;
    #1 chk("rst_cycle_rden", 32'(rd_en[0]), 32'd0);
    tick();
    chk("mid_rst_valid", 32'(vld[0]), 32'd0);
    chk("mid_rst_data",  data[0], 32'd0);
    chk("mid_rst_src",   32'(src[0]), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_src",  32'(src[0]), 32'd0);
    chk("post_rst_data", data[0], 32'h81);
    tick();
    chk("post_rst_src2",  32'(src[0]), 32'd2);
    chk("post_rst_data2", data[0], 32'h92);
    tick();
    chk("post_rst_drained", 32'(vld[0]), 32'd0);

    // Burst grants of 4 on the BURST=4 instance.
    for (int k = 0; k < 6; k++) begin
      push(1, 0, 32'(8'h00 + 8'(k)));
      push(1, 1, 32'(8'h10 + 8'(k)));
    end
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("burst_valid", 32'(vld[1]), 32'd1);
      chk("burst_src",   32'(src[1]), 32'(t6_s[k]));
      chk("burst_data",  data[1], 32'(t6_d[k]));
    end
    tick();
    chk("burst_drained", 32'(vld[1]), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
